// File: rtl/input_snapshot.sv
// Per-player input snapshot block: latches controller state on the vblank rising edge,
// accumulates spinner deltas between frames and exposes everything through a byte register map.
module input_snapshot #(
    parameter int PLAYERS  = 6,
    parameter int SPIN_SAT = 32767
) (
    input  logic                   clk_sys,
    input  logic                   reset,
    input  logic                   vblank,
    input  logic [PLAYERS*32-1:0]  joystick,
    input  logic [PLAYERS*16-1:0]  analog,
    input  logic [PLAYERS*8-1:0]   paddle,
    input  logic [PLAYERS*9-1:0]   spinner,
    input  logic [7:0]             cpu_addr,
    input  logic                   cpu_rd,
    input  logic                   cpu_wr,
    input  logic [7:0]             cpu_din,
    output logic [7:0]             cpu_dout,
    output logic                   irq
);

    localparam logic signed [16:0] SAT_P = 17'(SPIN_SAT);
    localparam logic signed [16:0] SAT_N = -SAT_P;

    logic                vblank_q, vblank_d;
    logic [31:0]         joy_q       [PLAYERS];
    logic [31:0]         joy_d       [PLAYERS];
    logic [15:0]         ana_q       [PLAYERS];
    logic [15:0]         ana_d       [PLAYERS];
    logic [7:0]          pad_q       [PLAYERS];
    logic [7:0]          pad_d       [PLAYERS];
    logic [15:0]         spin_snap_q [PLAYERS];
    logic [15:0]         spin_snap_d [PLAYERS];
    logic signed [15:0]  acc_q       [PLAYERS];
    logic signed [15:0]  acc_d       [PLAYERS];
    logic [PLAYERS-1:0]  tog_q, tog_d;
    logic [7:0]          chg_q, chg_d;
    logic [7:0]          irq_en_q, irq_en_d;
    logic [7:0]          frame_q, frame_d;
    logic [7:0]          dout_q, dout_d;
    logic                irq_q, irq_d;

    logic                capture;
    logic [7:0]          chg_set;
    logic [7:0]          w1c_mask;
    logic [7:0]          rd_data;
    logic [3:0]          rd_player;
    logic [3:0]          rd_off;
    logic                rd_hit;
    logic [31:0]         sel_joy;
    logic [15:0]         sel_ana;
    logic [7:0]          sel_pad;
    logic [15:0]         sel_spin;
    logic                sel_chg;

    function automatic logic signed [15:0] sat_add(input logic signed [15:0] a,
                                                   input logic signed [7:0]  d);
        logic signed [16:0] s;
        s = {a[15], a} + {{9{d[7]}}, d};
        if (s > SAT_P)
            return SAT_P[15:0];
        else if (s < SAT_N)
            return SAT_N[15:0];
        else
            return s[15:0];
    endfunction

    always_comb begin
        vblank_d    = vblank;
        capture     = vblank & ~vblank_q;
        joy_d       = joy_q;
        ana_d       = ana_q;
        pad_d       = pad_q;
        spin_snap_d = spin_snap_q;
        acc_d       = acc_q;
        tog_d       = tog_q;
        chg_set     = '0;

        for (int p = 0; p < PLAYERS; p++) begin
            tog_d[p] = spinner[9*p+8];
            if (capture) begin
                joy_d[p] = joystick[32*p +: 32];
                ana_d[p] = analog[16*p +: 16];
                pad_d[p] = paddle[8*p +: 8];
                // A delta arriving on the capture edge belongs to the frame being closed.
                spin_snap_d[p] = (spinner[9*p+8] != tog_q[p])
                               ? sat_add(acc_q[p], spinner[9*p +: 8])
                               : acc_q[p];
                acc_d[p] = '0;
                if (joystick[32*p +: 32] != joy_q[p])
                    chg_set[p] = 1'b1;
            end else if (spinner[9*p+8] != tog_q[p]) begin
                acc_d[p] = sat_add(acc_q[p], spinner[9*p +: 8]);
            end
        end

        frame_d  = capture ? frame_q + 8'd1 : frame_q;
        w1c_mask = (cpu_wr && cpu_addr == 8'hF0) ? cpu_din : 8'h00;
        chg_d    = (chg_q & ~w1c_mask) | chg_set;
        irq_en_d = (cpu_wr && cpu_addr == 8'hF2) ? cpu_din : irq_en_q;
        irq_d    = |(chg_q & irq_en_q);
        dout_d   = cpu_rd ? rd_data : dout_q;
    end

    always_comb begin
        rd_player = cpu_addr[7:4];
        rd_off    = cpu_addr[3:0];
        rd_hit    = 1'b0;
        sel_joy   = '0;
        sel_ana   = '0;
        sel_pad   = '0;
        sel_spin  = '0;
        sel_chg   = 1'b0;
        rd_data   = 8'hFF;

        for (int p = 0; p < PLAYERS; p++) begin
            if (rd_player == 4'(p)) begin
                rd_hit   = 1'b1;
                sel_joy  = joy_q[p];
                sel_ana  = ana_q[p];
                sel_pad  = pad_q[p];
                sel_spin = spin_snap_q[p];
                sel_chg  = chg_q[p];
            end
        end

        if (rd_player == 4'hF) begin
            case (rd_off)
                4'h0:    rd_data = chg_q;
                4'h1:    rd_data = frame_q;
                4'h2:    rd_data = irq_en_q;
                default: rd_data = 8'hFF;
            endcase
        end else if (rd_hit) begin
            case (rd_off)
                4'h0:    rd_data = sel_joy[7:0];
                4'h1:    rd_data = sel_joy[15:8];
                4'h2:    rd_data = sel_joy[23:16];
                4'h3:    rd_data = sel_joy[31:24];
                4'h4:    rd_data = sel_ana[7:0];
                4'h5:    rd_data = sel_ana[15:8];
                4'h6:    rd_data = sel_pad;
                4'h7:    rd_data = sel_spin[7:0];
                4'h8:    rd_data = sel_spin[15:8];
                4'h9:    rd_data = {7'b0, sel_chg};
                default: rd_data = 8'hFF;
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            vblank_q <= 1'b0;
            for (int p = 0; p < PLAYERS; p++) begin
                joy_q[p]       <= '0;
                ana_q[p]       <= '0;
                pad_q[p]       <= '0;
                spin_snap_q[p] <= '0;
                acc_q[p]       <= '0;
                // Track the live toggle so the first cycle out of reset sees no delta.
                tog_q[p]       <= spinner[9*p+8];
            end
            chg_q    <= '0;
            irq_en_q <= '0;
            frame_q  <= '0;
            dout_q   <= '0;
            irq_q    <= 1'b0;
        end else begin
            vblank_q    <= vblank_d;
            joy_q       <= joy_d;
            ana_q       <= ana_d;
            pad_q       <= pad_d;
            spin_snap_q <= spin_snap_d;
            acc_q       <= acc_d;
            tog_q       <= tog_d;
            chg_q       <= chg_d;
            irq_en_q    <= irq_en_d;
            frame_q     <= frame_d;
            dout_q      <= dout_d;
            irq_q       <= irq_d;
        end
    end

    assign cpu_dout = dout_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_input_snapshot.sv
// Bench for input_snapshot: directed scenarios plus random traffic, compared cycle by cycle
// against an arithmetic model of snapshots, spinner sums, change flags and the register map.
module tb_input_snapshot;

    localparam int NP  = 2;
    localparam int SAT = 32767;

    logic              clk_sys = 1'b0;
    logic              reset;
    logic              vblank;
    logic [NP*32-1:0]  joystick;
    logic [NP*16-1:0]  analog;
    logic [NP*8-1:0]   paddle;
    logic [NP*9-1:0]   spinner;
    logic [7:0]        cpu_addr;
    logic              cpu_rd;
    logic              cpu_wr;
    logic [7:0]        cpu_din;
    logic [7:0]        cpu_dout;
    logic              irq;

    input_snapshot #(.PLAYERS(NP), .SPIN_SAT(SAT)) dut (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .vblank   (vblank),
        .joystick (joystick),
        .analog   (analog),
        .paddle   (paddle),
        .spinner  (spinner),
        .cpu_addr (cpu_addr),
        .cpu_rd   (cpu_rd),
        .cpu_wr   (cpu_wr),
        .cpu_din  (cpu_din),
        .cpu_dout (cpu_dout),
        .irq      (irq)
    );

    always #5 clk_sys = ~clk_sys;

    int n_cmp = 0;
    int n_bad = 0;

    // reference state: values as they should stand after the most recent edge
    int          m_vb;
    logic [31:0] m_joy  [NP];
    logic [15:0] m_ana  [NP];
    logic [7:0]  m_pad  [NP];
    int          m_spin [NP];
    int          m_acc  [NP];
    int          m_tog  [NP];
    logic [7:0]  m_chg, m_en, m_frame, m_dout;
    int          m_irq;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int clamp(input int v);
        if (v > SAT) return SAT;
        if (v < -SAT) return -SAT;
        return v;
    endfunction

    function automatic logic [7:0] m_read(input logic [7:0] a);
        int p, o;
        logic [15:0] s;
        p = int'(a[7:4]);
        o = int'(a[3:0]);
        if (p == 15) begin
            if (o == 0) return m_chg;
            if (o == 1) return m_frame;
            if (o == 2) return m_en;
            return 8'hFF;
        end
        if (p >= NP || o > 9) return 8'hFF;
        s = m_spin[p][15:0];
        case (o)
            0: return m_joy[p][7:0];
            1: return m_joy[p][15:8];
            2: return m_joy[p][23:16];
            3: return m_joy[p][31:24];
            4: return m_ana[p][7:0];
            5: return m_ana[p][15:8];
            6: return m_pad[p];
            7: return s[7:0];
            8: return s[15:8];
            default: return {7'b0, m_chg[p]};
        endcase
    endfunction

    // advance the model over one edge, clock the DUT, then compare outputs
    task automatic tick();
        logic [7:0] rdv, setm;
        logic signed [7:0] d8;
        int nirq, cap, tg;
        rdv  = m_read(cpu_addr);
        nirq = ((m_chg & m_en) != 8'h00) ? 1 : 0;
        cap  = (vblank && m_vb == 0) ? 1 : 0;
        setm = 8'h00;
        for (int p = 0; p < NP; p++) begin
            tg = int'(spinner[9*p+8]);
            d8 = spinner[9*p +: 8];
            if (tg != m_tog[p]) m_acc[p] = clamp(m_acc[p] + int'(d8));
            if (cap != 0) begin
                m_spin[p] = m_acc[p];
                m_acc[p]  = 0;
                if (joystick[32*p +: 32] != m_joy[p]) setm[p] = 1'b1;
                m_joy[p] = joystick[32*p +: 32];
                m_ana[p] = analog[16*p +: 16];
                m_pad[p] = paddle[8*p +: 8];
            end
            m_tog[p] = tg;
        end
        if (cap != 0) m_frame = m_frame + 8'd1;
        if (cpu_wr && cpu_addr == 8'hF0) m_chg = m_chg & ~cpu_din;
        m_chg = m_chg | setm;
        if (cpu_wr && cpu_addr == 8'hF2) m_en = cpu_din;
        if (cpu_rd) m_dout = rdv;
        m_irq = nirq;
        m_vb  = vblank ? 1 : 0;
        if (reset) begin
            m_vb = 0; m_chg = 0; m_en = 0; m_frame = 0; m_dout = 0; m_irq = 0;
            for (int p = 0; p < NP; p++) begin
                m_joy[p] = 0; m_ana[p] = 0; m_pad[p] = 0; m_spin[p] = 0; m_acc[p] = 0;
                m_tog[p] = int'(spinner[9*p+8]);
            end
        end
        @(posedge clk_sys);
        #1;
        check("dout", {24'b0, cpu_dout}, {24'b0, m_dout});
        check("irq", {31'b0, irq}, m_irq[31:0]);
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] v);
        cpu_rd = 1'b1; cpu_addr = a;
        tick();
        cpu_rd = 1'b0;
        v = cpu_dout;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        cpu_wr = 1'b1; cpu_addr = a; cpu_din = d;
        tick();
        cpu_wr = 1'b0;
    endtask

    task automatic pulse();
        vblank = 1'b1; tick();
        vblank = 1'b0; tick();
    endtask

    task automatic spin(input int p, input logic [7:0] d);
        spinner[9*p +: 8] = d;
        spinner[9*p+8]    = ~spinner[9*p+8];
        tick();
    endtask

    initial begin
        logic [7:0] v, f0;
        reset = 1'b1; vblank = 1'b0; joystick = '0; analog = '0; paddle = '0; spinner = '0;
        cpu_addr = 8'h00; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_din = 8'h00;
        m_vb = 0; m_chg = 0; m_en = 0; m_frame = 0; m_dout = 0; m_irq = 0;
        for (int p = 0; p < NP; p++) begin
            m_joy[p] = 0; m_ana[p] = 0; m_pad[p] = 0; m_spin[p] = 0; m_acc[p] = 0; m_tog[p] = 0;
        end
        repeat (3) tick();
        reset = 1'b0;
        tick();
        rd(8'hF1, v); check("reset_frame", {24'b0, v}, 32'h00);

        // joystick capture, change flag and irq
        joystick[31:0] = 32'h0000_0010;
        analog[15:0] = 16'hF37A; paddle[7:0] = 8'h9C;
        wr(8'hF2, 8'h01);
        pulse();
        rd(8'h00, v); check("joy0_b0", {24'b0, v}, 32'h10);
        rd(8'h04, v); check("ana0_x", {24'b0, v}, 32'h7A);
        rd(8'h06, v); check("pad0", {24'b0, v}, 32'h9C);
        rd(8'hF0, v); check("chg_mask", {24'b0, v}, 32'h01);
        rd(8'h09, v); check("chg_bit0", {24'b0, v}, 32'h01);
        check("irq_on", {31'b0, irq}, 32'h1);

        // three small spinner deltas
        repeat (3) spin(1, 8'h05);
        pulse();
        rd(8'h17, v); check("spin1_lo", {24'b0, v}, 32'h0F);
        rd(8'h18, v); check("spin1_hi", {24'b0, v}, 32'h00);
        pulse();
        rd(8'h17, v); check("spin1_cleared", {24'b0, v}, 32'h00);

        // negative saturation
        repeat (300) spin(0, 8'h80);
        pulse();
        rd(8'h07, v); check("spin0_sat_lo", {24'b0, v}, 32'h01);
        rd(8'h08, v); check("spin0_sat_hi", {24'b0, v}, 32'h80);

        // W1C against a same-cycle set
        wr(8'hF0, 8'hFF);
        rd(8'hF0, v); check("w1c_clear", {24'b0, v}, 32'h00);
        tick();
        check("irq_off", {31'b0, irq}, 32'h0);
        joystick[31:0] = 32'h0000_0020;
        vblank = 1'b1; cpu_wr = 1'b1; cpu_addr = 8'hF0; cpu_din = 8'h01;
        tick();
        vblank = 1'b0; cpu_wr = 1'b0;
        tick();
        rd(8'hF0, v); check("set_wins", {24'b0, v}, 32'h01);

        // simultaneous read and write returns the pre-write value
        cpu_rd = 1'b1; cpu_wr = 1'b1; cpu_addr = 8'hF2; cpu_din = 8'h03;
        tick();
        cpu_rd = 1'b0; cpu_wr = 1'b0;
        check("rd_wr_pre", {24'b0, cpu_dout}, 32'h01);
        rd(8'hF2, v); check("rd_wr_post", {24'b0, v}, 32'h03);

        // frame counter wrap and unmapped reads
        f0 = m_frame;
        repeat (256) pulse();
        rd(8'hF1, v); check("frame_wrap", {24'b0, v}, {24'b0, f0});
        rd(8'h20, v); check("bad_player", {24'b0, v}, 32'hFF);
        rd(8'h0A, v); check("bad_offset", {24'b0, v}, 32'hFF);
        rd(8'hF3, v); check("bad_global", {24'b0, v}, 32'hFF);
        wr(8'h20, 8'h55);
        wr(8'hF1, 8'h55);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) joystick = {$urandom(), $urandom()};
            analog = NP*16'($urandom());
            paddle = NP*8'($urandom());
            for (int p = 0; p < NP; p++)
                if ($urandom_range(0, 2) == 0) begin
                    spinner[9*p +: 8] = 8'($urandom());
                    spinner[9*p+8]    = ~spinner[9*p+8];
                end
            vblank = ($urandom_range(0, 5) == 0);
            cpu_rd = ($urandom_range(0, 1) == 0);
            cpu_wr = ($urandom_range(0, 4) == 0);
            case ($urandom_range(0, 3))
                0:       cpu_addr = 8'hF0 + 8'($urandom_range(0, 3));
                1:       cpu_addr = 8'($urandom());
                default: cpu_addr = {4'($urandom_range(0, NP - 1)), 4'($urandom_range(0, 10))};
            endcase
            cpu_din = 8'($urandom());
            tick();
        end
        vblank = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0;
        tick();

        // reset mid-frame with accumulated spinner
        wr(8'hF2, 8'hFF);
        repeat (4) spin(0, 8'h11);
        reset = 1'b1;
        spinner[8] = ~spinner[8];
        spinner[17] = ~spinner[17];
        tick(); tick();
        reset = 1'b0;
        tick();
        for (int p = 0; p < NP; p++)
            for (int o = 0; o < 10; o++) begin
                rd({4'(p), 4'(o)}, v);
                check($sformatf("rst_p%0d_o%0d", p, o), {24'b0, v}, 32'h00);
            end
        rd(8'hF0, v); check("rst_chg", {24'b0, v}, 32'h00);
        rd(8'hF1, v); check("rst_frame", {24'b0, v}, 32'h00);
        rd(8'hF2, v); check("rst_en", {24'b0, v}, 32'h00);
        check("rst_irq", {31'b0, irq}, 32'h0);
        joystick = '0;
        pulse();
        rd(8'h07, v); check("no_spurious_lo", {24'b0, v}, 32'h00);
        rd(8'h08, v); check("no_spurious_hi", {24'b0, v}, 32'h00);
        rd(8'h17, v); check("no_spurious_p1", {24'b0, v}, 32'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
